// File: rtl/feature_mac_pkg.sv
// Shared widths, FSM state type and weight sign-extension for the feature MAC.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package feature_mac_pkg;

  localparam int W_DATA   = 3;                   // signed rectangle weight
  localparam int W_ADDR   = 8;                   // feature index / ROM address
  localparam int W_RECT   = 18;                  // unsigned rectangle sum
  localparam int W_PROD   = W_RECT + W_DATA + 1; // one weighted term
  localparam int W_FEAT   = W_RECT + W_DATA + 2; // three-term sum, no overflow
  localparam int NUM_RECT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    MAC   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Two's complement weight widened to the feature width.
  function automatic logic signed [W_FEAT-1:0] sext_weight(input logic [W_DATA-1:0] w);
    return {{(W_FEAT-W_DATA){w[W_DATA-1]}}, w};
  endfunction

endpackage

// File: rtl/feature_weight_mac_rect_mac.sv
// One signed multiply-add term: sum = acc + sext(w) * zext(rect).
// Latency: combinational, zero cycles.
// Backpressure: none; the caller sequences the operands.
module rect_mac
  import feature_mac_pkg::*;
(
  input  logic signed [W_FEAT-1:0] acc,
  input  logic        [W_DATA-1:0] w,
  input  logic        [W_RECT-1:0] rect,
  output logic signed [W_FEAT-1:0] sum
);

  logic signed [W_FEAT-1:0] w_ext;
  logic signed [W_FEAT-1:0] rect_ext;
  logic signed [W_PROD-1:0] prod;

  assign w_ext    = sext_weight(w);
  // Rect sums are magnitudes, so the top bits are always zero.
  assign rect_ext = $signed({{(W_FEAT-W_RECT){1'b0}}, rect});
  // The product always fits W_PROD bits; the upper bits are pure sign copies.
  assign prod     = W_PROD'(w_ext * rect_ext);
  assign sum      = acc + W_FEAT'(prod);

endmodule

// File: rtl/feature_weight_mac.sv
// Haar feature value: fetch three weights by address, then sum w_i*rect_i.
// Latency: accept at edge T gives out_valid from edge T+4.
// Backpressure: single request in flight; in_ready only in IDLE, result held until out_ready.
module feature_weight_mac
  import feature_mac_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic        [W_ADDR-1:0] in_addr,
  input  logic        [W_RECT-1:0] in_rect0,
  input  logic        [W_RECT-1:0] in_rect1,
  input  logic        [W_RECT-1:0] in_rect2,
  output logic                     w_en,
  output logic        [W_ADDR-1:0] w_addr,
  input  logic        [W_DATA-1:0] w0_data,
  input  logic        [W_DATA-1:0] w1_data,
  input  logic        [W_DATA-1:0] w2_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [W_FEAT-1:0] out_feat,
  output logic        [W_ADDR-1:0] out_addr
);

  state_t                   state;
  logic [1:0]               cnt;
  logic signed [W_FEAT-1:0] acc;
  logic signed [W_FEAT-1:0] acc_nxt;
  logic [W_ADDR-1:0]        addr_q;
  logic [W_RECT-1:0]        rect_q [NUM_RECT];
  logic [W_DATA-1:0]        w_q    [NUM_RECT];
  logic [W_RECT-1:0]        rect_sel;
  logic [W_DATA-1:0]        w_sel;
  logic                     accept;

  // in_ready is gated by rst so nothing is accepted while reset is held.
  assign in_ready  = rst && (state == IDLE);
  assign accept    = in_valid && in_ready;
  // The ROM read is issued in the same cycle as the accept so data lands in FETCH.
  assign w_en      = accept;
  assign w_addr    = (state == IDLE) ? in_addr : addr_q;
  assign out_valid = (state == DONE);
  assign out_feat  = acc;
  assign out_addr  = addr_q;

  // Pick the weight/rect pair for the current MAC step.
  always_comb begin
    rect_sel = rect_q[0];
    w_sel    = w_q[0];
    case (cnt)
      2'd1: begin
        rect_sel = rect_q[1];
        w_sel    = w_q[1];
      end
      2'd2: begin
        rect_sel = rect_q[2];
        w_sel    = w_q[2];
      end
      default: ;
    endcase
  end

  rect_mac u_rect_mac (
    .acc  (acc),
    .w    (w_sel),
    .rect (rect_sel),
    .sum  (acc_nxt)
  );

  // Request FSM: latch request, capture ROM weights, three MAC steps, hold result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      addr_q <= '0;
      for (int i = 0; i < NUM_RECT; i++) begin
        rect_q[i] <= '0;
        w_q[i]    <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q    <= in_addr;
            rect_q[0] <= in_rect0;
            rect_q[1] <= in_rect1;
            rect_q[2] <= in_rect2;
            state     <= FETCH;
          end
        end
        FETCH: begin
          w_q[0] <= w0_data;
          w_q[1] <= w1_data;
          w_q[2] <= w2_data;
          acc    <= '0;
          cnt    <= '0;
          state  <= MAC;
        end
        MAC: begin
          acc <= acc_nxt;
          if (cnt == 2'd2) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
